seq_mul16: RTL and testbench

SEQ_MUL16 -- requirements
Module: seq_mul16

---
 rtl/seq_mul16.sv | 161 ++++++++++++++++
 tb/tb_seq_mul16.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/seq_mul16.sv
// seq_mul16 -- sequential shift-add unsigned multiplier, one product bit per cycle.
//
// An operand pair is accepted in IDLE, iterated for N cycles in BUSY, and the
// 2N-bit product is presented in DONE until the consumer takes it. Only one
// operation is in flight at a time.
//
// Ports:
//   clk        clock, all state updates on its rising edge
//   rst        asynchronous, active-high reset
//   in_valid   operand pair a/b is valid
//   in_ready   block can accept an operand pair (IDLE)
//   a, b       unsigned multiplicand / multiplier, N bits
//   out_valid  p holds a finished product (DONE)
//   out_ready  consumer takes p
//   p          unsigned product a*b, 2N bits
//   busy       an iteration is in progress (BUSY)
//
// Configuration macro:
//   SEQ_MUL16_ZERO_BYPASS_EN  when defined, an accepted pair with a zero operand
//                             goes straight to DONE with p = 0.

module seq_mul16 #(
  parameter int unsigned N = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*N-1:0]   p,
  output logic             busy
);

  // Counter holds 0..N without wrapping.
  localparam int unsigned CW = $clog2(N) + 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;

  logic [N-1:0]    mcand;
  logic [N-1:0]    hi;
  logic [N-1:0]    lo;
  logic [CW-1:0]   cnt;

  logic            accept;
  logic            zero_op;
  logic [N:0]      sum;

  // Handshake qualifiers; acceptance is decided from the state register only.
  assign accept = in_valid && (state == IDLE);

`ifdef SEQ_MUL16_ZERO_BYPASS_EN
  assign zero_op = (a == '0) || (b == '0);
`else
  assign zero_op = 1'b0;
`endif

  // Partial-product add: the carry bit is kept as the new top bit of hi.
  assign sum = {1'b0, hi} + {1'b0, mcand & {N{lo[0]}}};

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = zero_op ? DONE : BUSY;
        end
      end
      BUSY: begin
        if (cnt == LAST_STEP) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Status outputs registered from the next state so they track the state register exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      in_ready  <= (state_next == IDLE);
      busy      <= (state_next == BUSY);
      out_valid <= (state_next == DONE);
    end
  end

  // Datapath: load on acceptance, one shift-add step per BUSY cycle, hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand <= '0;
      hi    <= '0;
      lo    <= '0;
      cnt   <= '0;
    end else if (accept) begin
      mcand <= a;
      hi    <= '0;
      // A bypassed zero operand must leave the product register at zero.
      lo    <= zero_op ? '0 : b;
      cnt   <= '0;
    end else if (state == BUSY) begin
      {hi, lo} <= {sum, lo[N-1:1]};
      cnt      <= cnt + CW'(1);
    end
  end

  // Product is the accumulator pair itself; it only moves while BUSY, so it is stable in DONE.
  assign p = {hi, lo};

  // Product and valid must not change while a presented result waits for the consumer.
  property p_hold_stable;
    @(posedge clk) disable iff (rst)
      (out_valid && !out_ready) |=> (out_valid && $stable(p));
  endproperty
  a_hold_stable : assert property (p_hold_stable);

  // The iteration counter never exceeds N.
  property p_cnt_range;
    @(posedge clk) disable iff (rst)
      cnt <= CW'(N);
  endproperty
  a_cnt_range : assert property (p_cnt_range);

  // Exactly one status output is high at a time.
  property p_onehot_status;
    @(posedge clk) disable iff (rst)
      $onehot({in_ready, busy, out_valid});
  endproperty
  a_onehot_status : assert property (p_onehot_status);

endmodule

// File: tb/tb_seq_mul16.sv
// tb_seq_mul16 -- self-checking bench for seq_mul16 (N = 16).
// Table-driven directed vectors plus hand-written multi-cycle sequences:
// held output, mid-operation reset, and back-to-back traffic.

module tb_seq_mul16;

  localparam int unsigned N = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [N-1:0]    a;
  logic [N-1:0]    b;
  logic            out_valid;
  logic            out_ready;
  logic [2*N-1:0]  p;
  logic            busy;

  int checks = 0;
  int passes = 0;

  typedef struct {
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic [2*N-1:0] p;
  } vec_t;

  vec_t vecs [10];

  seq_mul16 #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  // Advance one clock and land 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Edges between the accepting edge and the first cycle with out_valid visible.
  function automatic int exp_lat(input logic [N-1:0] va, input logic [N-1:0] vb);
`ifdef SEQ_MUL16_ZERO_BYPASS_EN
    if (va == '0 || vb == '0) return 0;
`endif
    return N;
  endfunction

  // One full transaction: accept, wait, optionally hold the result, then hand it off.
  task automatic run_op(input logic [N-1:0] va, input logic [N-1:0] vb,
                        input logic [2*N-1:0] vp, input int hold,
                        input logic orb, input string tag);
    int lat;
    logic [2*N-1:0] held;
    bit ok;
    a = va; b = vb; in_valid = 1'b1; out_ready = 1'b0;
    check($sformatf("%s in_ready_idle", tag), 64'(in_ready), 64'd1);
    tick();
    // Scramble the inputs after acceptance; the result must not care.
    in_valid = 1'b0; a = N'($urandom); b = N'($urandom);
    out_ready = orb;
    if (exp_lat(va, vb) != 0) check($sformatf("%s busy", tag), 64'(busy), 64'd1);
    lat = 0;
    while (!out_valid && lat < 200) begin
      tick();
      lat++;
    end
    out_ready = 1'b0;
    check($sformatf("%s latency", tag), 64'(lat), 64'(exp_lat(va, vb)));
    check($sformatf("%s product", tag), 64'(p), 64'(vp));
    held = p;
    ok = 1'b1;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; a = N'($urandom); b = N'($urandom);
      tick();
      if (p !== held || in_ready !== 1'b0 || out_valid !== 1'b1) ok = 1'b0;
    end
    if (hold > 0) check($sformatf("%s held_stable", tag), 64'(ok), 64'd1);
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check($sformatf("%s in_ready_after", tag), 64'(in_ready), 64'd1);
    check($sformatf("%s out_valid_after", tag), 64'(out_valid), 64'd0);
  endtask

  initial begin
    logic [2*N-1:0] exp_q;
    bit outstanding;
    bit acc;
    bit seen;
    int done_n;
    int cyc;

    vecs[0] = '{16'd12345,  16'd43210,  32'd533427450};
    vecs[1] = '{16'hFFFF,   16'hFFFF,   32'hFFFE0001};
    vecs[2] = '{16'h7FFF,   16'h8000,   32'h3FFF8000};
    vecs[3] = '{16'h0000,   16'h1234,   32'h00000000};
    vecs[4] = '{16'hABCD,   16'h0000,   32'h00000000};
    vecs[5] = '{16'h0001,   16'hFFFF,   32'h0000FFFF};
    vecs[6] = '{16'hFFFF,   16'h0002,   32'h0001FFFE};
    vecs[7] = '{16'h8000,   16'h8000,   32'h40000000};
    vecs[8] = '{16'h1234,   16'h5678,   32'h06260060};
    vecs[9] = '{16'd255,    16'd255,    32'd65025};

    // Reset state, with in_valid high to show nothing is accepted during reset.
    rst = 1'b1; in_valid = 1'b1; a = 16'd5; b = 16'd5; out_ready = 1'b0;
    #1;
    check("reset in_ready", 64'(in_ready), 64'd1);
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset p", 64'(p), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check("in_reset not_accepted", 64'({in_ready, busy}), 64'b10);
    rst = 1'b0; in_valid = 1'b0;
    tick();

    // Directed vectors; out_ready is held high while BUSY and must be ignored.
    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].p, 0, 1'b1, $sformatf("vec%0d", i));
    end

    // Held result with a competing in_valid during the wait.
    run_op(16'd3, 16'd5, 32'd15, 10, 1'b0, "hold3x5");

    // Reset on cycle 7 of an operation aborts it immediately.
    a = 16'd100; b = 16'd200; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (7) tick();
    rst = 1'b1;
    #1;
    check("abort out_valid", 64'(out_valid), 64'd0);
    check("abort in_ready", 64'(in_ready), 64'd1);
    check("abort busy", 64'(busy), 64'd0);
    check("abort p", 64'(p), 64'd0);
    tick();
    tick();
    rst = 1'b0;
    seen = 1'b0;
    repeat (20) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    check("abort no_out_valid", 64'(seen), 64'd0);
    run_op(16'd100, 16'd200, 32'd20000, 0, 1'b0, "after_abort");

    // Back-to-back traffic with in_valid held high and random out_ready.
    in_valid = 1'b1; a = N'($urandom); b = N'($urandom);
    outstanding = 1'b0; exp_q = '0; done_n = 0; cyc = 0;
    while (done_n < 20 && cyc < 5000) begin
      out_ready = 1'($urandom_range(0, 1));
      acc = 1'b0;
      if (in_ready) begin
        check("b2b no_overlap", 64'(outstanding), 64'd0);
        exp_q = {{N{1'b0}}, a} * {{N{1'b0}}, b};
        outstanding = 1'b1;
        acc = 1'b1;
      end
      if (out_valid && out_ready) begin
        check($sformatf("b2b product%0d", done_n), 64'(p), 64'(exp_q));
        outstanding = 1'b0;
        done_n++;
      end
      tick();
      if (acc) begin
        a = N'($urandom); b = N'($urandom);
      end
      cyc++;
    end
    check("b2b completed", 64'(done_n), 64'd20);
    in_valid = 1'b0; out_ready = 1'b0;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
